tty_bit_sched: RTL and testbench
================================

// Module: tty_bit_sched
// PURPOSE
// - Bit-timing scheduler for the console teletype (device 120) shift registers.
// - Free-running transmit tick: one clk-wide pulse per bit time, gated by tto_en.
// - Receive tick phase-aligned to the start of a character, sampling at mid-bit.
// - Counts units per frame; pulses rx_done when the character is complete.
// - Sits between the tty I/O logic and the UART pins; replaces fixed 110/150 Hz dividers.
// PARAMETERS
// CLK_HZ    50_000_000  system clock frequency
// BAUD_A    110         baud when baud_sel=0; DIV_A = CLK_HZ/BAUD_A (truncated)
// BAUD_B    150         baud when baud_sel=1; DIV_B = CLK_HZ/BAUD_B (truncated)
// SIM_DIV   8           divisor for both rates when TTY_SIM_FAST_EN is defined (even, >=4)
// PORTS
// clk       in   1   system clock, all state on posedge
// reset     in   1   asynchronous, active-low; 0 forces the reset state immediately
// baud_sel  in   1   0=BAUD_A, 1=BAUD_B
// unit11    in   1   0=10-unit frame, 1=11-unit frame (2 stop bits)
// tto_en    in   1   transmitter active; level
// rx_act    in   1   receiver active (start bit seen); level, rising edge starts frame
// tto_tick  out  1   1-cycle pulse: shift transmitter
// tti_tick  out  1   1-cycle pulse: sample/shift receiver at mid-bit
// rx_done   out  1   1-cycle pulse, coincident with last tti_tick of frame
// rx_bits   out  4   tti_tick count in current frame, 0..11
// rx_busy   out  1   1 while RX state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, RX state IDLE, both counters 0, rx_act edge register 0.
// - DIV = baud_sel ? DIV_B : DIV_A; HALF = DIV>>1. Counter width $clog2(DIV_A+1).
// TX divider
// - tto_en=0: counter held at DIV-1, no tto_tick.
// - tto_en=1: counter decrements each cycle; at 0 assert tto_tick, reload DIV-1.
// - First tto_tick exactly DIV cycles after the first cycle tto_en is sampled high.
// - baud_sel is sampled only on reload; mid-bit changes take effect next bit.
// - Dropping tto_en mid-bit: tick suppressed from that cycle on, counter reloaded.
// RX state machine (IDLE, HALF, RUN)
// - rx_rise = rx_act & ~rx_act_q (rx_act_q registered each cycle).
// - IDLE: on rx_rise -> HALF, cnt=HALF-1, rx_bits=0, latch baud_sel/unit11 for frame.
// - HALF: cnt decrements; at 0 assert tti_tick, rx_bits=1, cnt=DIV-1 -> RUN.
// - RUN: cnt decrements; at 0 assert tti_tick, rx_bits+1, reload DIV-1.
// - Tick making rx_bits == 10 (11 if latched unit11): rx_done=1 same cycle -> IDLE.
// - rx_act low in HALF or RUN: -> IDLE next edge, no tick that cycle (abort wins).
// - After rx_done, a new frame needs a fresh rising edge of rx_act.
// - rx_rise outside IDLE is ignored; rx_bits holds its value in IDLE until next rx_rise.
// - First tti_tick HALF cycles after entering HALF, then every DIV cycles.
// - TX and RX are independent; simultaneous ticks are legal.
// - Async reset mid-frame: immediate IDLE, outputs 0; no rx_done.
// CONFIGURATION
// - TTY_SIM_FAST_EN defined: DIV_A = DIV_B = SIM_DIV (baud_sel ignored for rate).
// - Not defined: divisors derived from CLK_HZ/BAUD_A/BAUD_B as above.
// - All other behaviour identical.
// TESTING (TTY_SIM_FAST_EN, SIM_DIV=8 unless stated)
// 1 reset=0 mid-activity -> all outputs 0 at once; release, tto_en=0 -> no ticks 100 cyc.
// 2 tto_en=1 at cycle 0 -> tto_tick at cycles 8,16,24,...; tto_en=0 at 20 -> none after 16.
// 3 rx_act rises, enters HALF at cycle N, unit11=0 -> tti_tick at N+4,N+12..N+76.
//   rx_done only at N+76, rx_bits=10, rx_busy falls next cycle.
// 4 unit11=1 -> 11 ticks, rx_done at N+84, rx_bits=11; unit11 toggled mid-frame ignored.
// 5 rx_act low at N+30 -> no tick at N+36, no rx_done, IDLE at N+31; re-rise restarts.
// 6 No macro, CLK_HZ=1_100, BAUD_A=110, BAUD_B=150 -> DIV=10 (sel 0) / 7 (sel 1) tick spacing.

Source files
------------

// File: rtl/tty_bit_sched.sv
// Bit-timing scheduler for the console teletype shift registers: a free-running TX
// bit tick and a start-aligned mid-bit RX tick. Define TTY_SIM_FAST_EN to use SIM_DIV for both rates.

module tty_bit_sched #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD_A  = 110,
    parameter int BAUD_B  = 150,
    parameter int SIM_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_sel,
    input  logic       unit11,
    input  logic       tto_en,
    input  logic       rx_act,
    output logic       tto_tick,
    output logic       tti_tick,
    output logic       rx_done,
    output logic [3:0] rx_bits,
    output logic       rx_busy
);

`ifdef TTY_SIM_FAST_EN
    localparam int DIV_A = SIM_DIV;
    localparam int DIV_B = SIM_DIV;
`else
    localparam int DIV_A = CLK_HZ / BAUD_A;
    localparam int DIV_B = CLK_HZ / BAUD_B;
`endif
    localparam int CW = $clog2(DIV_A + 1);

    localparam logic [CW-1:0] DIV_A_M1  = CW'(DIV_A - 1);
    localparam logic [CW-1:0] DIV_B_M1  = CW'(DIV_B - 1);
    localparam logic [CW-1:0] DIV_A_M2  = CW'(DIV_A - 2);
    localparam logic [CW-1:0] DIV_B_M2  = CW'(DIV_B - 2);
    localparam logic [CW-1:0] HALF_A_M1 = CW'((DIV_A >> 1) - 1);
    localparam logic [CW-1:0] HALF_B_M1 = CW'((DIV_B >> 1) - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HALF,
        RX_RUN
    } rx_state_e;

    rx_state_e     rx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [CW-1:0] rx_cnt_q;
    logic          tx_en_q;
    logic          tto_tick_q;
    logic          rx_act_q;
    logic          rx_sel_q;
    logic          rx_u11_q;
    logic          tti_tick_q;
    logic          rx_done_q;
    logic          rx_busy_q;
    logic [3:0]    rx_bits_q;

    logic [CW-1:0] tx_reload_d;
    logic [CW-1:0] tx_first_d;
    logic [CW-1:0] rx_half_d;
    logic [CW-1:0] rx_reload_d;
    logic          rx_rise_d;
    logic [3:0]    rx_bits_d;
    logic [3:0]    rx_last_d;

    // RX rate and frame length come from values latched at the start bit, so
    // mid-frame changes on baud_sel/unit11 cannot stretch or truncate a character.
    assign tx_reload_d = baud_sel ? DIV_B_M1 : DIV_A_M1;
    assign tx_first_d  = baud_sel ? DIV_B_M2 : DIV_A_M2;
    assign rx_half_d   = baud_sel ? HALF_B_M1 : HALF_A_M1;
    assign rx_reload_d = rx_sel_q ? DIV_B_M1 : DIV_A_M1;
    assign rx_rise_d   = rx_act & ~rx_act_q;
    assign rx_bits_d   = rx_bits_q + 4'd1;
    assign rx_last_d   = rx_u11_q ? 4'd11 : 4'd10;

    // The first enabled cycle acts as the first decrement from DIV-1, so the
    // first tick lands DIV cycles later regardless of the counter's prior value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt_q   <= '0;
            tx_en_q    <= 1'b0;
            tto_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // independent of statement order across always_ff blocks.
            tx_en_q    <= tto_en;
            tto_tick_q <= 1'b0;
            if (!tto_en) begin
                tx_cnt_q <= tx_reload_d;
            end else if (!tx_en_q) begin
                tx_cnt_q <= tx_first_d;
            end else if (tx_cnt_q == '0) begin
                tto_tick_q <= 1'b1;
                tx_cnt_q   <= tx_reload_d;
            end else begin
                tx_cnt_q <= tx_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_act_q   <= 1'b0;
            rx_sel_q   <= 1'b0;
            rx_u11_q   <= 1'b0;
            tti_tick_q <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
            rx_bits_q  <= '0;
        end else begin
            rx_act_q   <= rx_act;
            tti_tick_q <= 1'b0;
            rx_done_q  <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    rx_busy_q <= 1'b0;
                    if (rx_rise_d) begin
                        rx_state_q <= RX_HALF;
                        rx_cnt_q   <= rx_half_d;
                        rx_bits_q  <= '0;
                        rx_sel_q   <= baud_sel;
                        rx_u11_q   <= unit11;
                        rx_busy_q  <= 1'b1;
                    end
                end
                RX_HALF, RX_RUN: begin
                    if (!rx_act) begin
                        rx_state_q <= RX_IDLE;
                        rx_busy_q  <= 1'b0;
                    end else if (rx_cnt_q == '0) begin
                        tti_tick_q <= 1'b1;
                        rx_bits_q  <= rx_bits_d;
                        rx_cnt_q   <= rx_reload_d;
                        rx_state_q <= RX_RUN;
                        // rx_busy stays high through the done cycle and drops in IDLE.
                        if (rx_bits_d == rx_last_d) begin
                            rx_done_q  <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CW'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign tto_tick = tto_tick_q;
    assign tti_tick = tti_tick_q;
    assign rx_done  = rx_done_q;
    assign rx_bits  = rx_bits_q;
    assign rx_busy  = rx_busy_q;

endmodule

// File: tb/tb_tty_bit_sched.sv
// Self-checking bench for tty_bit_sched: randomized TX/RX stimulus checked every
// cycle against a tick-time reference model derived from the divisor arithmetic.

module tb_tty_bit_sched;

    localparam int CLK_HZ  = 1_100;
    localparam int BAUD_A  = 110;
    localparam int BAUD_B  = 150;
    localparam int SIM_DIV = 8;
`ifdef TTY_SIM_FAST_EN
    localparam int DA = SIM_DIV;
    localparam int DB = SIM_DIV;
`else
    localparam int DA = CLK_HZ / BAUD_A;
    localparam int DB = CLK_HZ / BAUD_B;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       baud_sel = 1'b0;
    logic       unit11   = 1'b0;
    logic       tto_en   = 1'b0;
    logic       rx_act   = 1'b0;
    logic       tto_tick;
    logic       tti_tick;
    logic       rx_done;
    logic [3:0] rx_bits;
    logic       rx_busy;
    logic [7:0] dut_vec;

    always #5 clk = ~clk;

    tty_bit_sched #(
        .CLK_HZ  (CLK_HZ),
        .BAUD_A  (BAUD_A),
        .BAUD_B  (BAUD_B),
        .SIM_DIV (SIM_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_sel (baud_sel),
        .unit11   (unit11),
        .tto_en   (tto_en),
        .rx_act   (rx_act),
        .tto_tick (tto_tick),
        .tti_tick (tti_tick),
        .rx_done  (rx_done),
        .rx_bits  (rx_bits),
        .rx_busy  (rx_busy)
    );

    assign dut_vec = {tto_tick, tti_tick, rx_done, rx_bits, rx_busy};

    int checks = 0;
    int errors = 0;

    // Reference model: tick instants are computed as absolute edge numbers.
    int         cyc       = 0;
    bit         tx_run    = 0;
    int         tx_next   = 0;
    bit         rx_prev   = 0;
    bit         rx_active = 0;
    int         rx_n0     = 0;
    int         rx_d      = 0;
    int         rx_len    = 0;
    logic [3:0] m_bits    = '0;
    logic [7:0] exp_vec   = '0;

    function automatic int div_of(input logic sel);
        return sel ? DB : DA;
    endfunction

    task automatic model_reset();
        tx_run    = 0;
        rx_active = 0;
        rx_prev   = 0;
        m_bits    = '0;
        exp_vec   = '0;
    endtask

    task automatic model_edge();
        bit t_tick = 0;
        bit r_tick = 0;
        bit r_done = 0;
        bit r_busy = 0;
        int ph;
        cyc++;
        if (!tto_en) begin
            tx_run = 0;
        end else begin
            if (!tx_run) begin
                tx_run  = 1;
                tx_next = cyc + div_of(baud_sel) - 1;
            end
            if (cyc == tx_next) begin
                t_tick  = 1;
                tx_next = cyc + div_of(baud_sel);
            end
        end
        if (rx_active) begin
            if (!rx_act) begin
                rx_active = 0;
            end else begin
                r_busy = 1;
                ph = cyc - rx_n0 - rx_d / 2;
                if (ph >= 0 && (ph % rx_d) == 0) begin
                    r_tick = 1;
                    m_bits = 4'(ph / rx_d + 1);
                    if (int'(m_bits) == rx_len) begin
                        r_done    = 1;
                        rx_active = 0;
                    end
                end
            end
        end else if (rx_act && !rx_prev) begin
            rx_active = 1;
            rx_n0     = cyc;
            rx_d      = div_of(baud_sel);
            rx_len    = unit11 ? 11 : 10;
            m_bits    = '0;
            r_busy    = 1;
        end
        rx_prev = rx_act;
        exp_vec = {t_tick, r_tick, r_done, m_bits, r_busy};
    endtask

    // Advance one clock, update the model, and return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        else       model_reset();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
        end
        reset  = 1'b1;
        tto_en = 1'b1;
        rx_act = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_pre cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", dut_vec, 8'h00);
        end
        tto_en = 1'b0;
        rx_act = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_tx();
        for (int r = 0; r < 7; r++) begin
            int d;
            int len;
            int first;
            baud_sel = 1'($urandom_range(0, 1));
            d        = div_of(baud_sel);
            len      = (r == 0) ? 2 * d + 4 : $urandom_range(d + 1, 5 * d);
            first    = 0;
            tto_en   = 1'b1;
            for (int i = 1; i <= len; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL tx_run cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
                if (tto_tick === 1'b1 && first == 0) first = i;
            end
            checks++;
            if (first != d) begin
                errors++;
                $display("FAIL tx_first_tick got=%0d exp=%0d", first, d);
            end
            tto_en = 1'b0;
            for (int i = 0; i < 2 * DA; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL tx_stop cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_tx_sel_change();
        for (int r = 0; r < 3; r++) begin
            int flip_at;
            baud_sel = 1'b0;
            tto_en   = 1'b1;
            flip_at  = $urandom_range(DA + 1, 2 * DA - 1);
            for (int i = 1; i <= 6 * DA; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL tx_sel_change cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
                if (i == flip_at) baud_sel = ~baud_sel;
            end
            tto_en = 1'b0;
            step();
        end
    endtask

    task automatic test_rx_frame();
        for (int r = 0; r < 6; r++) begin
            int d;
            int len;
            int dones;
            int flip_at;
            baud_sel = 1'($urandom_range(0, 1));
            unit11   = 1'($urandom_range(0, 1));
            d        = div_of(baud_sel);
            len      = unit11 ? 11 : 10;
            flip_at  = $urandom_range(2, 5 * d);
            dones    = 0;
            rx_act   = 1'b1;
            for (int i = 1; i <= d / 2 + 11 * d + 4; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL rx_frame cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
                if (rx_done === 1'b1) dones++;
                if (i == flip_at) begin
                    unit11   = ~unit11;
                    baud_sel = ~baud_sel;
                end
            end
            checks++;
            if (dones != 1) begin
                errors++;
                $display("FAIL rx_done_count got=%0d exp=%0d", dones, 1);
            end
            checks++;
            if (rx_bits !== 4'(len)) begin
                errors++;
                $display("FAIL rx_bits_final got=%0d exp=%0d", rx_bits, len);
            end
            rx_act = 1'b0;
            step();
        end
    endtask

    task automatic test_rx_abort();
        for (int r = 0; r < 4; r++) begin
            int d;
            int k;
            int dones;
            baud_sel = 1'($urandom_range(0, 1));
            unit11   = 1'($urandom_range(0, 1));
            d        = div_of(baud_sel);
            k        = $urandom_range(1, d / 2 + 9 * d);
            dones    = 0;
            rx_act   = 1'b1;
            for (int i = 1; i <= k; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL rx_abort_pre cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
            end
            rx_act = 1'b0;
            for (int i = 0; i < 3 + d; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL rx_abort_idle cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
                if (rx_done === 1'b1) dones++;
            end
            checks++;
            if (dones != 0) begin
                errors++;
                $display("FAIL rx_abort_done got=%0d exp=%0d", dones, 0);
            end
            rx_act = 1'b1;
            for (int i = 1; i <= d / 2 + 11 * d + 2; i++) begin
                step();
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL rx_restart cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
                end
            end
            rx_act = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        tto_en = 1'b1;
        rx_act = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, dut_vec, exp_vec);
            end
            if (exp_vec[5])                          rx_act = 1'b0;
            else if (!rx_act)                        rx_act = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 199) == 0)    rx_act = 1'b0;
            if ($urandom_range(0, 59) == 0) tto_en   = ~tto_en;
            if ($urandom_range(0, 29) == 0) baud_sel = ~baud_sel;
            unit11 = 1'($urandom_range(0, 1));
        end
        tto_en = 1'b0;
        rx_act = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_sel_change();
        test_rx_frame();
        test_rx_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
